// File: rtl/mul_shift_add.sv
// Iterative 32x32 radix-2 shift-add multiplier with signed/unsigned modes.
// Optional: define MUL_ZERO_BYPASS_EN to finish zero-operand products in one cycle.
module mul_shift_add (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        valid,
    input  logic        sign,
    output logic        mul_stall,
    output logic [63:0] result
);

    typedef enum logic {
        S_IDLE,
        S_BUSY
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [4:0]  r_cnt;
    logic [31:0] r_mcand;
    logic [31:0] r_mplier;
    logic [63:0] r_acc;
    logic        r_neg;
    logic        r_stall;
    logic [31:0] w_a_abs;
    logic [31:0] w_b_abs;
    logic [32:0] w_sum;
    logic        w_start;
    logic        w_last;

    // 0x80000000 negates to itself, which is the correct unsigned magnitude
    assign w_a_abs = (sign && a[31]) ? (~a + 32'd1) : a;
    assign w_b_abs = (sign && b[31]) ? (~b + 32'd1) : b;
    assign w_start = (r_state == S_IDLE) && valid;
    assign w_sum   = {1'b0, r_acc[63:32]}
                   + {1'b0, (r_mplier[0] ? r_mcand : 32'd0)};

`ifdef MUL_ZERO_BYPASS_EN
    logic r_zero;
    logic w_zero;
    assign w_zero = (a == 32'd0) || (b == 32'd0);
    assign w_last = (r_cnt == 5'd31) || r_zero;
`else
    assign w_last = (r_cnt == 5'd31);
`endif

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: if (valid)  w_next = S_BUSY;
            S_BUSY: if (w_last) w_next = S_IDLE;
            default:            w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_stall <= 1'b0;
        end else begin
            r_state <= w_next;
            r_stall <= (w_next == S_BUSY);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt    <= 5'd0;
            r_mcand  <= 32'd0;
            r_mplier <= 32'd0;
            r_acc    <= 64'd0;
            r_neg    <= 1'b0;
        end else if (w_start) begin
            r_cnt    <= 5'd0;
            r_mcand  <= w_a_abs;
            r_mplier <= w_b_abs;
            r_acc    <= 64'd0;
            r_neg    <= sign && (a[31] ^ b[31]);
        end else if (r_state == S_BUSY) begin
            // Shift {carry, acc, multiplier}; acc low bit feeds the spent multiplier
            r_acc    <= {w_sum, r_acc[31:1]};
            r_mplier <= {r_acc[0], r_mplier[31:1]};
            r_cnt    <= r_cnt + 5'd1;
        end
    end

`ifdef MUL_ZERO_BYPASS_EN
    always_ff @(posedge clk) begin
        if (!rst)         r_zero <= 1'b0;
        else if (w_start) r_zero <= w_zero;
    end
`endif

    assign mul_stall = r_stall;
    assign result    = r_neg ? (~r_acc + 64'd1) : r_acc;

endmodule
